// File: rtl/vga_sync_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen_if
// Description : Monitor coordinate bus and sync pins from the VGA timing master.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_gen_if;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       line_tick;
    logic       frame_tick;
    logic [7:0] frame_cnt;

    modport master (
        output hc, vc, valid, hsync, vsync, line_tick, frame_tick, frame_cnt
    );

    modport slave (
        input  hc, vc, valid, hsync, vsync, line_tick, frame_tick, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA timing master: pixel/line counters, delayed syncs, frame strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 2
) (
    input  logic                  clk_25m,
    input  logic                  rst,
    vga_sync_gen_if.master        vga_o
);

    localparam int         c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_act    = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_act    = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       c_sync_on  = SYNC_POL;
    localparam logic       c_sync_off = ~SYNC_POL;

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       valid_q, valid_d;
    logic       line_q, line_d;
    logic       frame_q, frame_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hs_raw_q, hs_raw_d;
    logic       vs_raw_q, vs_raw_d;

    // Every flag is decoded from the next count so it lands on the same
    // cycle as the hc/vc value it describes.
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == c_h_last) begin
            hc_d = '0;
            vc_d = (vc_q == c_v_last) ? '0 : vc_q + 10'd1;
        end
        valid_d  = (hc_d < c_h_act) && (vc_d < c_v_act);
        line_d   = (hc_d == '0);
        frame_d  = (hc_d == '0) && (vc_d == c_v_act);
        cnt_d    = frame_d ? cnt_q + 8'd1 : cnt_q;
        hs_raw_d = ((hc_d >= c_hs_start) && (hc_d < c_hs_end)) ? c_sync_on : c_sync_off;
        vs_raw_d = ((vc_d >= c_vs_start) && (vc_d < c_vs_end)) ? c_sync_on : c_sync_off;
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            hc_q     <= c_h_last;
            vc_q     <= c_v_last;
            valid_q  <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            cnt_q    <= '0;
            hs_raw_q <= c_sync_off;
            vs_raw_q <= c_sync_off;
        end else begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            valid_q  <= valid_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            hs_raw_q <= hs_raw_d;
            vs_raw_q <= vs_raw_d;
        end
    end

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign vga_o.hsync = hs_raw_q;
            assign vga_o.vsync = vs_raw_q;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_pipe_q;
            logic [PIPE_DLY-1:0] vs_pipe_q;

            // Delay matches the ROM read plus the colour output register.
            always_ff @(posedge clk_25m) begin
                if (rst) begin
                    hs_pipe_q <= {PIPE_DLY{c_sync_off}};
                    vs_pipe_q <= {PIPE_DLY{c_sync_off}};
                end else begin
                    hs_pipe_q[0] <= hs_raw_q;
                    vs_pipe_q[0] <= vs_raw_q;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        hs_pipe_q[i] <= hs_pipe_q[i-1];
                        vs_pipe_q[i] <= vs_pipe_q[i-1];
                    end
                end
            end

            assign vga_o.hsync = hs_pipe_q[PIPE_DLY-1];
            assign vga_o.vsync = vs_pipe_q[PIPE_DLY-1];
        end
    endgenerate

    assign vga_o.hc         = hc_q;
    assign vga_o.vc         = vc_q;
    assign vga_o.valid      = valid_q;
    assign vga_o.line_tick  = line_q;
    assign vga_o.frame_tick = frame_q;
    assign vga_o.frame_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Directed self-checking bench for vga_sync_gen (three configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    logic clk_25m = 1'b0;
    logic rst     = 1'b1;
    logic rst_sm  = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #20 clk_25m = ~clk_25m;

    vga_sync_gen_if if_def ();
    vga_sync_gen_if if_p0 ();
    vga_sync_gen_if if_sm ();

    vga_sync_gen u_def (
        .clk_25m (clk_25m),
        .rst     (rst),
        .vga_o   (if_def)
    );

    vga_sync_gen #(
        .PIPE_DLY (0),
        .SYNC_POL (1'b1)
    ) u_p0 (
        .clk_25m (clk_25m),
        .rst     (rst),
        .vga_o   (if_p0)
    );

    // Small raster: 16 clocks per line, 8 lines, 128 clocks per frame.
    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b0),
        .PIPE_DLY (3)
    ) u_sm (
        .clk_25m (clk_25m),
        .rst     (rst_sm),
        .vga_o   (if_sm)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_25m);
        @(negedge clk_25m);
    endtask

    initial begin
        int valid_n, hs_low_n, lt_n, ft_n, hc_bad, valid_bad, hs_bad, p0_bad, vc_bad;
        int first_hs, prev_vc;
        int sm_ft_n, sm_ft_idx, sm_ft_cnt, sm_vs_low, sm_vs_first, sm_vc_bad, ticks;

        // Reset held for 5 cycles
        repeat (5) @(posedge clk_25m);
        @(negedge clk_25m);
        chk("rst_hc",        if_def.hc, 799);
        chk("rst_vc",        if_def.vc, 524);
        chk("rst_valid",     if_def.valid, 0);
        chk("rst_hsync",     if_def.hsync, 1);
        chk("rst_vsync",     if_def.vsync, 1);
        chk("rst_frame_cnt", if_def.frame_cnt, 0);
        chk("rst_line_tick", if_def.line_tick, 0);
        chk("rst_frm_tick",  if_def.frame_tick, 0);
        chk("p0_rst_hsync",  if_p0.hsync, 0);
        chk("p0_rst_vsync",  if_p0.vsync, 0);

        rst    = 1'b0;
        rst_sm = 1'b0;
        step();
        chk("rel_hc",        if_def.hc, 0);
        chk("rel_vc",        if_def.vc, 0);
        chk("rel_valid",     if_def.valid, 1);
        chk("rel_line_tick", if_def.line_tick, 1);
        chk("rel_hsync",     if_def.hsync, 1);

        // One full line from release
        valid_n = 0; hs_low_n = 0; lt_n = 0; ft_n = 0;
        hc_bad = 0; valid_bad = 0; hs_bad = 0; p0_bad = 0; vc_bad = 0;
        first_hs = 1023;
        for (int i = 0; i < 800; i++) begin
            if (int'(if_def.hc) != i) hc_bad++;
            if (if_def.vc !== 10'd0) vc_bad++;
            if (if_def.valid) valid_n++;
            if (if_def.valid !== (i < 640)) valid_bad++;
            if (if_def.hsync === 1'b0) begin
                hs_low_n++;
                if (first_hs == 1023) first_hs = i;
            end
            if ((if_def.hsync === 1'b0) != (i >= 658 && i <= 753)) hs_bad++;
            if ((if_p0.hsync === 1'b1) != (i >= 656 && i <= 751)) p0_bad++;
            if (if_def.line_tick) lt_n++;
            if (if_def.frame_tick) ft_n++;
            step();
        end
        chk("line_hc_seq",    hc_bad, 0);
        chk("line_vc_hold",   vc_bad, 0);
        chk("line_valid_n",   valid_n, 640);
        chk("line_valid_pos", valid_bad, 0);
        chk("line_hs_low_n",  hs_low_n, 96);
        chk("line_hs_first",  first_hs, 658);
        chk("line_hs_pos",    hs_bad, 0);
        chk("p0_hs_pos",      p0_bad, 0);
        chk("line_tick_n",    lt_n, 1);
        chk("line_ftick_n",   ft_n, 0);
        chk("wrap_hc",        if_def.hc, 0);
        chk("wrap_vc",        if_def.vc, 1);
        chk("wrap_line_tick", if_def.line_tick, 1);

        // Mid-frame reset while hsync is active in the pipeline
        repeat (700) step();
        chk("pre_rst_hc",    if_def.hc, 700);
        chk("pre_rst_hsync", if_def.hsync, 0);
        chk("pre_rst_p0_hs", if_p0.hsync, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_hc",    if_def.hc, 799);
        chk("mid_rst_vc",    if_def.vc, 524);
        chk("mid_rst_valid", if_def.valid, 0);
        chk("mid_rst_hsync", if_def.hsync, 1);
        chk("mid_rst_vsync", if_def.vsync, 1);
        chk("mid_rst_fcnt",  if_def.frame_cnt, 0);
        chk("mid_rst_p0_hs", if_p0.hsync, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("resume_hc",    if_def.hc, k);
            chk("resume_vc",    if_def.vc, 0);
            chk("resume_hsync", if_def.hsync, 1);
        end

        // Small raster: one full frame from a fresh reset
        rst_sm = 1'b1;
        step();
        chk("sm_rst_hc",    if_sm.hc, 15);
        chk("sm_rst_vc",    if_sm.vc, 7);
        chk("sm_rst_vsync", if_sm.vsync, 1);
        rst_sm = 1'b0;
        step();
        chk("sm_rel_hc", if_sm.hc, 0);
        chk("sm_rel_vc", if_sm.vc, 0);
        sm_ft_n = 0; sm_ft_idx = -1; sm_ft_cnt = -1;
        sm_vs_low = 0; sm_vs_first = -1; sm_vc_bad = 0;
        prev_vc = 0;
        for (int i = 0; i < 128; i++) begin
            if (int'(if_sm.vc) != prev_vc && if_sm.hc !== 10'd0) sm_vc_bad++;
            prev_vc = int'(if_sm.vc);
            if (if_sm.frame_tick) begin
                sm_ft_n++;
                sm_ft_idx = i;
                sm_ft_cnt = int'(if_sm.frame_cnt);
            end
            if (if_sm.vsync === 1'b0) begin
                sm_vs_low++;
                if (sm_vs_first < 0) sm_vs_first = i;
            end
            step();
        end
        chk("sm_ftick_n",   sm_ft_n, 1);
        chk("sm_ftick_idx", sm_ft_idx, 64);
        chk("sm_fcnt_1",    sm_ft_cnt, 1);
        chk("sm_vs_low_n",  sm_vs_low, 32);
        chk("sm_vs_first",  sm_vs_first, 83);
        chk("sm_vc_adv",    sm_vc_bad, 0);
        chk("sm_period_hc", if_sm.hc, 0);
        chk("sm_period_vc", if_sm.vc, 0);

        // Run on to the 256th frame_tick and watch frame_cnt wrap
        ticks = 1;
        for (int n = 0; n < 256 * 128 && ticks < 256; n++) begin
            step();
            if (if_sm.frame_tick) begin
                ticks++;
                if (ticks == 255) chk("sm_fcnt_255", if_sm.frame_cnt, 255);
                if (ticks == 256) chk("sm_fcnt_wrap", if_sm.frame_cnt, 0);
            end
        end
        chk("sm_ticks_256", ticks, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
